parking_log: RTL
================

# parking_log

Per-day car log for the parking-lot simulation, directly downstream of the hour-tracking FSM. Consumes its `hours` and `endDay` outputs together with the `enter` and `exit` pulses. Maintains lot occupancy, counts accepted entries per hour, and captures the rush-hour window. At end of day it replays the eight per-hour counts on a scan port for display.

## Interface

Parameters:
- `CAPACITY`, default 3. Lot size; the maximum occupancy.
- `COUNT_W`, default 4. Width of each per-hour entry counter.
- `DWELL`, default 4. Clock cycles each hour is held on the scan port (DWELL ≥ 1).

Ports:
- `clk`  in  1  System clock, one clock domain.
- `reset`  in  1  Asynchronous, active-high. Clears all state.
- `enter`  in  1  One-cycle pulse: a car requests entry.
- `exit`  in  1  One-cycle pulse: a car leaves.
- `hours`  in  3  Current hour, 0–7, from the hour FSM.
- `endDay`  in  1  High while the hour FSM is in its display state.
- `occupancy`  out  OCC_W  Cars currently in the lot, where OCC_W = $clog2(CAPACITY+1).
- `full`  out  1  High when occupancy == CAPACITY.
- `empty`  out  1  High when occupancy == 0.
- `scanValid`  out  1  Scan outputs are valid.
- `scanHour`  out  3  Hour currently shown on the scan port.
- `scanCount`  out  COUNT_W  Entries recorded for `scanHour`.
- `rushStartValid`  out  1  The lot has become full today.
- `rushStart`  out  3  Hour in which the lot first became full.
- `rushEndValid`  out  1  The lot emptied after the rush.
- `rushEnd`  out  3  Hour in which the lot first emptied after the rush started.

## Operation

- The state machine has two states, RECORD and SCAN. Reset enters RECORD.
- **RECORD, per cycle:**
  - `enter` is accepted if occupancy < CAPACITY, or if `exit` is also high. Otherwise it is rejected: no count, no occupancy change.
  - `exit` is accepted if occupancy > 0, or if an enter is accepted in the same cycle.
  - Occupancy changes by +1 for an accepted enter alone, −1 for an accepted exit alone, and 0 when both are accepted.
  - An accepted enter increments `counts[hours]`. The counter saturates at 2^COUNT_W − 1.
- **Rush capture (RECORD only):**
  - The first cycle in which occupancy becomes CAPACITY sets `rushStartValid`, and `rushStart` takes the value of `hours` in that cycle. Later fill events do not update it.
  - After `rushStartValid` is set, the first cycle in which occupancy becomes 0 sets `rushEndValid`, and `rushEnd` takes the value of `hours` in that cycle.
- **RECORD → SCAN** when `endDay` is sampled high. Scan index and dwell counter are set to 0.
- **SCAN:**
  - `enter` and `exit` are ignored.
  - Each index is held for DWELL cycles, then the index advances. Index 7 wraps to 0.
  - `scanHour` = index and `scanCount` = `counts[index]`.
  - Counts and rush registers are frozen.
- **SCAN → RECORD** when `endDay` is sampled low. On that same edge, all counts, occupancy, rush valid flags and rush values are cleared to 0, and `scanValid` drops. This starts a new day.
- Asserting `reset` at any time, including mid-scan, immediately forces every register to its reset value.

## Timing

- All outputs are registered, except `full` and `empty`, which are decoded from the occupancy register. No combinational path runs from any input to any output.
- Reset values:
  - `occupancy` = 0, `empty` = 1, `full` = 0.
  - `scanValid` = 0, `scanHour` = 0, `scanCount` = 0.
  - Both rush valid flags = 0, `rushStart` = 0, `rushEnd` = 0.
  - All counts = 0.
- Latency:
  - An enter or exit sampled at edge N is reflected in `occupancy`, the counts and the rush outputs after edge N.
  - `endDay` sampled high at edge N gives `scanValid` = 1 with `scanHour` = 0 after edge N. Index 0 is held through edge N+DWELL, and `scanHour` = 1 appears after edge N+DWELL.
  - `endDay` sampled low gives `scanValid` = 0 after that edge.
- An enter that arrives in the same cycle `endDay` rises is still processed under RECORD rules, counted against `hours`.

## Structure

- Package `parking_pkg`:
  - `typedef logic [2:0] hour_t`
  - `NUM_HOURS = 8`
  - the log state enum {RECORD, SCAN}
- Sub-module `entry_bank`:
  - NUM_HOURS saturating COUNT_W-bit counters.
  - Ports: increment-enable with hour index, synchronous clear, and read index with read data.
  - Asynchronous reset, same as the parent.
- The top level holds the occupancy/accept logic, rush capture, the state machine, and the dwell/index counters.

## Test plan

All scenarios use CAPACITY = 3 and DWELL = 2.
- **Basic entry and exit:** reset, then enter ×2 at hours = 0 → occupancy 2, counts[0] = 2, `empty` = 0, `full` = 0. Then exit ×2 → occupancy 0 and `empty` = 1.
- **Full lot:** enter ×3 at hours = 1 → `full` = 1, `rushStartValid` = 1, `rushStart` = 1. A 4th enter is rejected: occupancy 3, counts[1] stays 3. Simultaneous enter+exit while full → occupancy 3, counts[1] = 4.
- **Rush end and underflow:** after the full scenario, exit ×3 at hours = 4 → `rushEndValid` = 1, `rushEnd` = 4. An extra exit at occupancy 0 leaves occupancy at 0.
- **Saturation:** 20 accepted enters at hours = 2, with interleaved exits → counts[2] = 15.
- **Scan sequence:** raise `endDay` → the scan port shows hours 0..7 with their counts, each for 2 cycles, then wraps to 0. Enters during the scan do not change occupancy. Dropping `endDay` → `scanValid` = 0, occupancy and counts are all 0, and both rush valid flags = 0.
- **Reset mid-scan:** assert `reset` asynchronously mid-scan at scanHour = 3 → all outputs are at their reset values before the next clock edge, and the block is in RECORD.

Source files
------------

// File: rtl/parking_pkg.sv
// rtl/parking_pkg.sv - shared types for the parking-lot car log
package parking_pkg;

  typedef logic [2:0] hour_t;

  localparam int NUM_HOURS = 8;

  typedef enum logic {
    RECORD = 1'b0,
    SCAN   = 1'b1
  } log_state_t;

endpackage

// File: rtl/parking_log_entry_bank.sv
// rtl/parking_log_entry_bank.sv - per-hour saturating entry counters
module entry_bank
  import parking_pkg::*;
#(
  parameter int COUNT_W = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               inc,
  input  hour_t              inc_hour,
  input  logic               clear,
  input  hour_t              rd_hour,
  output logic [COUNT_W-1:0] rd_data
);

  localparam logic [COUNT_W-1:0] COUNT_MAX = '1;

  logic [COUNT_W-1:0] counts [NUM_HOURS];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_HOURS; i++) counts[i] <= '0;
    end else if (clear) begin
      for (int i = 0; i < NUM_HOURS; i++) counts[i] <= '0;
    end else if (inc && counts[inc_hour] != COUNT_MAX) begin
      counts[inc_hour] <= counts[inc_hour] + 1'b1;
    end
  end

  assign rd_data = counts[rd_hour];

endmodule

// File: rtl/parking_log.sv
// rtl/parking_log.sv - lot occupancy, per-hour entry log, rush capture and end-of-day scan
module parking_log
  import parking_pkg::*;
#(
  parameter  int CAPACITY = 3,
  parameter  int COUNT_W  = 4,
  parameter  int DWELL    = 4,
  localparam int OCC_W    = $clog2(CAPACITY + 1)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               enter,
  input  logic               exit,
  input  hour_t              hours,
  input  logic               endDay,
  output logic [OCC_W-1:0]   occupancy,
  output logic               full,
  output logic               empty,
  output logic               scanValid,
  output hour_t              scanHour,
  output logic [COUNT_W-1:0] scanCount,
  output logic               rushStartValid,
  output hour_t              rushStart,
  output logic               rushEndValid,
  output hour_t              rushEnd
);

  localparam int                 DW_W       = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [DW_W-1:0]    DWELL_LAST = DW_W'(DWELL - 1);
  localparam logic [OCC_W-1:0]   CAP        = OCC_W'(CAPACITY);
  localparam logic [COUNT_W-1:0] COUNT_MAX  = '1;

  log_state_t         state;
  logic [DW_W-1:0]    dwell;
  logic               recording;
  logic               enter_ok;
  logic               exit_ok;
  logic [OCC_W-1:0]   next_occ;
  logic               fills;
  logic               drains;
  hour_t              next_idx;
  logic [COUNT_W-1:0] rd_data;
  logic [COUNT_W-1:0] scan_count_d;
  logic               bank_clear;

  assign recording = (state == RECORD);
  assign enter_ok  = recording && enter && (occupancy != CAP || exit);
  assign exit_ok   = recording && exit && (occupancy != '0 || enter_ok);

  always_comb begin
    next_occ = occupancy;
    if (enter_ok && !exit_ok)      next_occ = occupancy + 1'b1;
    else if (exit_ok && !enter_ok) next_occ = occupancy - 1'b1;
  end

  assign fills  = (next_occ == CAP) && (occupancy != CAP);
  assign drains = (next_occ == '0) && (occupancy != '0);

  always_comb begin
    next_idx = '0;
    if (!recording) next_idx = (dwell == DWELL_LAST) ? scanHour + 1'b1 : scanHour;
  end

  // An enter accepted on the edge that opens the scan lands in the bank on that
  // same edge, so forward it into the first displayed count.
  always_comb begin
    scan_count_d = rd_data;
    if (enter_ok && hours == next_idx && rd_data != COUNT_MAX) scan_count_d = rd_data + 1'b1;
  end

  assign bank_clear = (state == SCAN) && !endDay;

  entry_bank #(
    .COUNT_W (COUNT_W)
  ) u_bank (
    .clk      (clk),
    .reset    (reset),
    .inc      (enter_ok),
    .inc_hour (hours),
    .clear    (bank_clear),
    .rd_hour  (next_idx),
    .rd_data  (rd_data)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= RECORD;
      occupancy      <= '0;
      dwell          <= '0;
      scanValid      <= 1'b0;
      scanHour       <= '0;
      scanCount      <= '0;
      rushStartValid <= 1'b0;
      rushStart      <= '0;
      rushEndValid   <= 1'b0;
      rushEnd        <= '0;
    end else begin
      case (state)
        RECORD: begin
          occupancy <= next_occ;
          if (!rushStartValid && fills) begin
            rushStartValid <= 1'b1;
            rushStart      <= hours;
          end
          if (rushStartValid && !rushEndValid && drains) begin
            rushEndValid <= 1'b1;
            rushEnd      <= hours;
          end
          if (endDay) begin
            state     <= SCAN;
            scanValid <= 1'b1;
            scanHour  <= '0;
            scanCount <= scan_count_d;
            dwell     <= '0;
          end
        end
        SCAN: begin
          if (!endDay) begin
            state          <= RECORD;
            occupancy      <= '0;
            dwell          <= '0;
            scanValid      <= 1'b0;
            scanHour       <= '0;
            scanCount      <= '0;
            rushStartValid <= 1'b0;
            rushStart      <= '0;
            rushEndValid   <= 1'b0;
            rushEnd        <= '0;
          end else begin
            scanHour  <= next_idx;
            scanCount <= scan_count_d;
            dwell     <= (dwell == DWELL_LAST) ? '0 : dwell + 1'b1;
          end
        end
        default: state <= RECORD;
      endcase
    end
  end

  assign full  = (occupancy == CAP);
  assign empty = (occupancy == '0);

endmodule
